// File: rtl/rsp_buf_if.sv
// Response handshake bundle: valid/tag/data forward, stall backward.
// The master drives push/rdctl/data; the slave drives stall.
interface rsp_buf_if;
  logic        push;
  logic [31:0] rdctl;
  logic [63:0] data;
  logic        stall;

  modport master (output push, output rdctl, output data, input stall);
  modport slave  (input push, input rdctl, input data, output stall);
endinterface

// File: rtl/rsp_buf.sv
// rsp_buf: registered MC response intake, FIFO buffer, registered forward stage and run-control FSM.
// Optional statistics (max_occ, stall_cyc) are built only when RSP_BUF_STATS_EN is defined.
module rsp_buf #(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       edge_count,
  output logic              idle,
  output logic              done,
  rsp_buf_if.slave          mc,
  rsp_buf_if.master         ds,
  output logic              err_overflow,
  output logic              err_unexp,
  output logic [6:0]        max_occ,
  output logic [31:0]       stall_cyc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_r, state_nxt_s;
  logic          in_push_r;
  logic [31:0]   in_rdctl_r;
  logic [63:0]   in_data_r;
  logic [95:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] occ_r;
  logic [31:0]   remain_r;
  logic          out_push_r;
  logic [31:0]   out_rdctl_r;
  logic [63:0]   out_data_r;
  logic          err_overflow_r, err_unexp_r;
  logic          pop_s, wr_s, drop_s, start_acc_s, unexp_s, idle_s, done_s;

  // Per-cycle FIFO and control qualifiers.
  always_comb begin
    pop_s       = (occ_r != {CW{1'b0}}) && !ds.stall;
    wr_s        = in_push_r && ((occ_r != FULL_C) || pop_s);
    drop_s      = in_push_r && !wr_s;
    start_acc_s = (state_r == IDLE) && start;
    unexp_s     = in_push_r && (state_r != RUN);
  end

  // Stall is forced high during reset so the MC never pushes into a clearing buffer.
  assign mc.stall = !reset_n || (occ_r >= AFULL_C);

  // Input stage: one register level between MC and the FIFO write port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_push_r  <= 1'b0;
      in_rdctl_r <= 32'd0;
      in_data_r  <= 64'd0;
    end else begin
      in_push_r  <= mc.push;
      in_rdctl_r <= mc.rdctl;
      in_data_r  <= mc.data;
    end
  end

  // Storage array; a write into the slot being read on a full FIFO is safe (old value read).
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= {in_rdctl_r, in_data_r};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {CW{1'b0}};
    end else begin
      if (wr_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s) rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      case ({wr_s, pop_s})
        2'b10:   occ_r <= occ_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   occ_r <= occ_r - {{(CW-1){1'b0}}, 1'b1};
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Output stage: popped entry appears next cycle, tag/data hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_push_r  <= 1'b0;
      out_rdctl_r <= 32'd0;
      out_data_r  <= 64'd0;
    end else begin
      out_push_r <= pop_s;
      if (pop_s) begin
        {out_rdctl_r, out_data_r} <= mem_r[rd_ptr_r];
      end
    end
  end

  assign ds.push  = out_push_r;
  assign ds.rdctl = out_rdctl_r;
  assign ds.data  = out_data_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_nxt_s;
  end

  // FSM next state: a run ends once all expected pops happened and nothing is buffered or in flight.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if ((remain_r == 32'd0) && (occ_r == {CW{1'b0}}) && !in_push_r) state_nxt_s = DONE;
        else                                                            state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    idle_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      IDLE:    idle_s = !start;
      DONE:    done_s = 1'b1;
      default: idle_s = 1'b0;
    endcase
  end

  assign idle = idle_s;
  assign done = done_s;

  // Remaining-response counter, saturating at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      remain_r <= 32'd0;
    end else if (start_acc_s) begin
      remain_r <= edge_count;
    end else if ((state_r == RUN) && pop_s && (remain_r != 32'd0)) begin
      remain_r <= remain_r - 32'd1;
    end
  end

  // Sticky error flags; an event in the same cycle as the clearing start still records.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_overflow_r <= 1'b0;
      err_unexp_r    <= 1'b0;
    end else begin
      err_overflow_r <= (err_overflow_r & !start_acc_s) | drop_s;
      err_unexp_r    <= (err_unexp_r & !start_acc_s) | unexp_s;
    end
  end

  assign err_overflow = err_overflow_r;
  assign err_unexp    = err_unexp_r;

`ifdef RSP_BUF_STATS_EN
  logic [6:0]  max_occ_r;
  logic [31:0] stall_cyc_r;

  // Peak occupancy and stall-cycle statistics, restarted by each accepted start.
  always_ff @(posedge clk) begin
    if (!reset_n || start_acc_s) begin
      max_occ_r   <= 7'd0;
      stall_cyc_r <= 32'd0;
    end else begin
      if (7'(occ_r) > max_occ_r) max_occ_r <= 7'(occ_r);
      if (mc.stall) stall_cyc_r <= stall_cyc_r + 32'd1;
    end
  end

  assign max_occ   = max_occ_r;
  assign stall_cyc = stall_cyc_r;
`else
  assign max_occ   = 7'd0;
  assign stall_cyc = 32'd0;
`endif

endmodule

// File: doc/rsp_buf.md
RSP_BUF -- requirements
Module: rsp_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, response FIFO entries (power of 2, 4..64).
REQ-002 SHALL have parameter AFULL_LVL, default 10, occupancy at or above which mc_rsp_stall asserts.
REQ-003 Ports (name direction width meaning):
  clk  in  1  sole clock, all logic rising-edge.
  reset_n  in  1  synchronous, active-low reset.
  start  in  1  one-cycle pulse, arms a run.
  edge_count  in  32  responses expected this run, sampled on accepted start.
  idle  out  1  high in IDLE with start low.
  done  out  1  one-cycle pulse at run completion.
  mc_rsp_push  in  1  MC response valid.
  mc_rsp_rdctl  in  32  MC response tag.
  mc_rsp_data  in  64  MC response data.
  mc_rsp_stall  out  1  back-pressure to MC.
  out_push  out  1  response valid to downstream chaser.
  out_rdctl  out  32  forwarded tag.
  out_data  out  64  forwarded data.
  out_stall  in  1  downstream back-pressure.
  err_overflow  out  1  sticky, response dropped on full FIFO.
  err_unexp  out  1  sticky, response received outside RUN.
  max_occ  out  7  peak FIFO occupancy (config dependent).
  stall_cyc  out  32  cycles mc_rsp_stall was high (config dependent).

Function
REQ-004 SHALL register mc_rsp_push/rdctl/data one stage before the FIFO write.
REQ-005 SHALL write the registered response when registered push high and (occupancy < DEPTH or a pop occurs the same cycle).
REQ-006 SHALL drop a registered response arriving at occupancy == DEPTH with no same-cycle pop and set err_overflow.
REQ-007 SHALL drive mc_rsp_stall = (occupancy >= AFULL_LVL), combinational from occupancy, leaving DEPTH-AFULL_LVL slots for in-flight pushes.
REQ-008 SHALL pop when FIFO non-empty and out_stall low; popped entry registered onto out_push/out_rdctl/out_data next cycle.
REQ-009 Latency: mc_rsp_push at cycle N, empty FIFO, out_stall low -> out_push at N+3; one response per cycle sustained.
REQ-010 out_push SHALL be high one cycle per popped entry; out_rdctl/out_data hold last value when out_push low.
REQ-011 Simultaneous push and pop SHALL leave occupancy unchanged; order strictly FIFO.
REQ-012 States IDLE, RUN, DONE; DONE lasts one cycle, done high there.
REQ-013 IDLE -> RUN on start; load remain = edge_count.
REQ-014 RUN: remain decrements by 1 per FIFO pop; saturates at 0.
REQ-015 RUN -> DONE when remain == 0, FIFO empty, registered push low; edge_count 0 -> DONE on cycle after RUN entry.
REQ-016 DONE -> IDLE unconditionally.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 Responses arriving in IDLE/DONE SHALL still be buffered and forwarded, and set err_unexp.
REQ-019 start accepted in IDLE SHALL clear err_overflow and err_unexp.

Reset
REQ-020 reset_n low at a clock edge SHALL empty FIFO, state IDLE, remain 0, input stage cleared.
REQ-021 Reset values: out_push 0, out_rdctl 0, out_data 0, done 0, err_* 0, max_occ 0, stall_cyc 0, idle 1.
REQ-022 mc_rsp_stall SHALL read 1 while reset_n low, regardless of occupancy.
REQ-023 Reset mid-RUN SHALL discard all buffered and in-flight responses; no out_push after reset.

Configuration
REQ-024 Macro RSP_BUF_STATS_EN defined: max_occ tracks peak occupancy, stall_cyc counts mc_rsp_stall-high cycles (wrapping at 2^32), both cleared on reset and on accepted start.
REQ-025 RSP_BUF_STATS_EN undefined: max_occ and stall_cyc tied to 0, no counter logic.

Verification
REQ-026 start, edge_count=4, 4 pushes rdctl 0..3 back-to-back, out_stall 0 -> out_push 4 cycles in order starting N+3, done one cycle after last pop drains.
REQ-027 edge_count=0 start -> done pulse 2 cycles after start, no out_push, idle back high.
REQ-028 out_stall held 1, 16 pushes -> mc_rsp_stall rises when occupancy hits 10; 17th push drops, err_overflow=1; release out_stall -> exactly 16 entries out in order.
REQ-029 out_stall 1, FIFO full, push with out_stall released same cycle -> push accepted, no overflow, occupancy stays 16.
REQ-030 push in IDLE with data 0xDEAD -> forwarded, err_unexp=1; next start clears it.
REQ-031 reset_n low mid-RUN with 5 entries buffered -> outputs to reset values next cycle, idle 1, no further out_push; with RSP_BUF_STATS_EN, max_occ=5 before reset, 0 after.
